// File: rtl/local_ram_pkg.sv
// Shared definitions for the local RAM arbiter: port identifiers and default widths.
package local_ram_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 32;

   // The numeric value doubles as the bit index into the grant/request vectors.
   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

endpackage

// File: rtl/local_ram_arb_rr_arb2.sv
// Two-request round-robin arbiter; bit 0 is the instruction port, bit 1 the data port.
module rr_arb2
   import local_ram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   port_e last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // On conflict the port that did not win last time goes first.
         2'b11:   gnt = (last_grant == PORT_I) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= PORT_I;
      end else if (advance) begin
         last_grant <= gnt[1] ? PORT_D : PORT_I;
      end
   end

endmodule

// File: rtl/local_ram_arb.sv
// Shares the single-ported local RAM between the instruction-fetch and data buses,
// one access per cycle, returning registered read data to the port that asked.
module local_ram_arb
   import local_ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_rsp_valid,
   output logic [DATA_W-1:0]   i_rsp_rdata,

   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_wr,
   input  logic [DATA_W/8-1:0] d_req_be,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_rdata,

   output logic [DATA_W/8-1:0] ram_wr,
   output logic                ram_rd,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata
);

   // Handshake: a request transfers in the cycle where its valid and ready are
   // both high. Ready is combinational, at most one is high per cycle, and it is
   // never high without its own valid. Read data returns one cycle later with no
   // backpressure; writes complete at the handshake and return nothing.

   logic [1:0] req;
   logic [1:0] gnt;
   logic       pend_valid;
   port_e      pend_port;

   // Masking requests during reset keeps readies and RAM strobes low.
   assign req = reset ? 2'b00 : {d_req_valid, i_req_valid};

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (|gnt),
      .gnt     (gnt)
   );

   assign i_req_ready = gnt[PORT_I];
   assign d_req_ready = gnt[PORT_D];

   always_comb begin
      ram_wr    = '0;
      ram_rd    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (gnt[PORT_I]) begin
         ram_rd   = 1'b1;
         ram_addr = i_req_addr;
      end else if (gnt[PORT_D]) begin
         ram_addr = d_req_addr;
         if (d_req_wr) begin
            ram_wr    = d_req_be;
            ram_wdata = d_req_wdata;
         end else begin
            ram_rd = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_port  <= PORT_I;
      end else begin
         pend_valid <= gnt[PORT_I] | (gnt[PORT_D] & ~d_req_wr);
         pend_port  <= gnt[PORT_D] ? PORT_D : PORT_I;
      end
   end

   // A read still in flight when reset rises is dropped, not delivered.
   assign i_rsp_valid = pend_valid & (pend_port == PORT_I) & ~reset;
   assign d_rsp_valid = pend_valid & (pend_port == PORT_D) & ~reset;
   assign i_rsp_rdata = ram_rdata;
   assign d_rsp_rdata = ram_rdata;

endmodule

// File: tb/tb_local_ram_arb.sv
// Bench for local_ram_arb: directed vector table plus randomized traffic against a
// transaction-level model with its own shadow memory.
module tb_local_ram_arb;

   logic        clk;
   logic        reset;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [10:0] i_req_addr;
   logic        i_rsp_valid;
   logic [31:0] i_rsp_rdata;
   logic        d_req_valid;
   logic        d_req_ready;
   logic        d_req_wr;
   logic [3:0]  d_req_be;
   logic [10:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_rdata;
   logic [3:0]  ram_wr;
   logic        ram_rd;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int total = 0;
   int bad   = 0;

   local_ram_arb dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (i_req_valid),
      .i_req_ready (i_req_ready),
      .i_req_addr  (i_req_addr),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_rdata (i_rsp_rdata),
      .d_req_valid (d_req_valid),
      .d_req_ready (d_req_ready),
      .d_req_wr    (d_req_wr),
      .d_req_be    (d_req_be),
      .d_req_addr  (d_req_addr),
      .d_req_wdata (d_req_wdata),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_rdata (d_rsp_rdata),
      .ram_wr      (ram_wr),
      .ram_rd      (ram_rd),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- RAM stand-in (registered read, byte writes) ----------------
   logic [31:0] ram_mem [0:2047];

   function automatic logic [31:0] init_word(input int k);
      return (k == 16) ? 32'h1122_3344 : (32'hC0DE_0000 | 32'(k));
   endfunction

   always @(posedge clk) begin
      if (ram_rd) ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
         if (ram_wr[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:2047];
   logic        m_last_d;
   logic        m_pend_v;
   logic        m_pend_d;
   logic [31:0] m_pend_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, check just after, advance the model.
   task automatic step(input logic rst, input logic iv, input logic [10:0] ia,
                       input logic dv, input logic dwr, input logic [3:0] dbe,
                       input logic [10:0] da, input logic [31:0] dwd);
      logic gi, gd, e_rd, e_iv, e_dv;
      logic [3:0]  e_wr;
      logic [10:0] e_addr;
      @(negedge clk);
      reset       = rst;
      i_req_valid = iv;
      i_req_addr  = ia;
      d_req_valid = dv;
      d_req_wr    = dwr;
      d_req_be    = dbe;
      d_req_addr  = da;
      d_req_wdata = dwd;
      #1;
      gi = 1'b0;
      gd = 1'b0;
      if (!rst) begin
         if (iv && dv) begin
            gi = m_last_d;
            gd = !m_last_d;
         end else begin
            gi = iv;
            gd = dv;
         end
      end
      e_rd   = gi || (gd && !dwr);
      e_wr   = (gd && dwr) ? dbe : 4'b0000;
      e_addr = gi ? ia : (gd ? da : 11'd0);
      chk("i_req_ready", 32'(i_req_ready), 32'(gi));
      chk("d_req_ready", 32'(d_req_ready), 32'(gd));
      chk("ram_rd", 32'(ram_rd), 32'(e_rd));
      chk("ram_wr", 32'(ram_wr), 32'(e_wr));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (!e_rd) chk("ram_wdata", ram_wdata, (gd && dwr) ? dwd : 32'd0);

      e_iv = !rst && m_pend_v && !m_pend_d;
      e_dv = !rst && m_pend_v && m_pend_d;
      chk("i_rsp_valid", 32'(i_rsp_valid), 32'(e_iv));
      chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_dv));
      if (e_iv) chk("i_rsp_rdata", i_rsp_rdata, m_pend_data);
      if (e_dv) chk("d_rsp_rdata", d_rsp_rdata, m_pend_data);

      if (rst) begin
         m_last_d = 1'b0;
         m_pend_v = 1'b0;
      end else begin
         m_pend_v = 1'b0;
         if (gi) begin
            m_last_d    = 1'b0;
            m_pend_v    = 1'b1;
            m_pend_d    = 1'b0;
            m_pend_data = ref_mem[ia];
         end else if (gd) begin
            m_last_d = 1'b1;
            if (dwr) begin
               for (int b = 0; b < 4; b++) begin
                  if (dbe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
               end
            end else begin
               m_pend_v    = 1'b1;
               m_pend_d    = 1'b1;
               m_pend_data = ref_mem[da];
            end
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        rst;
      logic        iv;
      logic [10:0] ia;
      logic        dv;
      logic        dwr;
      logic [3:0]  dbe;
      logic [10:0] da;
      logic [31:0] dwd;
      logic        e_ir;
      logic        e_dr;
      logic        e_iv;
      logic        e_dv;
      logic [31:0] e_data;
   } vec_t;

   localparam int N_VEC = 28;
   vec_t tbl [N_VEC];

   function automatic vec_t mk(input int rst, input int iv, input int ia, input int dv,
                               input int dwr, input int dbe, input int da,
                               input logic [31:0] dwd, input int e_ir, input int e_dr,
                               input int e_iv, input int e_dv, input logic [31:0] e_data);
      vec_t v;
      v.rst    = 1'(rst);
      v.iv     = 1'(iv);
      v.ia     = 11'(ia);
      v.dv     = 1'(dv);
      v.dwr    = 1'(dwr);
      v.dbe    = 4'(dbe);
      v.da     = 11'(da);
      v.dwd    = dwd;
      v.e_ir   = 1'(e_ir);
      v.e_dr   = 1'(e_dr);
      v.e_iv   = 1'(e_iv);
      v.e_dv   = 1'(e_dv);
      v.e_data = e_data;
      return v;
   endfunction

   initial begin
      reset       = 1'b1;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      d_req_valid = 1'b0;
      d_req_wr    = 1'b0;
      d_req_be    = '0;
      d_req_addr  = '0;
      d_req_wdata = '0;
      m_last_d    = 1'b0;
      m_pend_v    = 1'b0;
      m_pend_d    = 1'b0;
      m_pend_data = '0;
      for (int k = 0; k < 2048; k++) begin
         ram_mem[k] <= init_word(k);
         ref_mem[k] = init_word(k);
      end

      //             rst iv  ia  dv wr be  da  wdata          ir dr iv dv data
      tbl[0]  = mk(1, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 0, 32'h0);
      tbl[1]  = mk(1, 1, 0,  1, 0, 0,  0,  32'h0,          0, 0, 0, 0, 32'h0);
      tbl[2]  = mk(0, 1, 0,  0, 0, 0,  0,  32'h0,          1, 0, 0, 0, 32'h0);
      tbl[3]  = mk(0, 1, 1,  0, 0, 0,  0,  32'h0,          1, 0, 1, 0, 32'hC0DE_0000);
      tbl[4]  = mk(0, 1, 2,  0, 0, 0,  0,  32'h0,          1, 0, 1, 0, 32'hC0DE_0001);
      tbl[5]  = mk(0, 1, 3,  0, 0, 0,  0,  32'h0,          1, 0, 1, 0, 32'hC0DE_0002);
      tbl[6]  = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 1, 0, 32'hC0DE_0003);
      tbl[7]  = mk(0, 0, 0,  1, 1, 5,  16, 32'hAABB_CCDD,  0, 1, 0, 0, 32'h0);
      tbl[8]  = mk(0, 0, 0,  1, 0, 0,  16, 32'h0,          0, 1, 0, 0, 32'h0);
      tbl[9]  = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 1, 32'h11BB_33DD);
      tbl[10] = mk(1, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 0, 32'h0);
      tbl[11] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          0, 1, 0, 0, 32'h0);
      tbl[12] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          1, 0, 0, 1, 32'hC0DE_0006);
      tbl[13] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          0, 1, 1, 0, 32'hC0DE_0005);
      tbl[14] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          1, 0, 0, 1, 32'hC0DE_0006);
      tbl[15] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          0, 1, 1, 0, 32'hC0DE_0005);
      tbl[16] = mk(0, 1, 5,  1, 0, 0,  6,  32'h0,          1, 0, 0, 1, 32'hC0DE_0006);
      tbl[17] = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 1, 0, 32'hC0DE_0005);
      tbl[18] = mk(0, 0, 0,  1, 1, 15, 32, 32'hDEAD_BEEF,  0, 1, 0, 0, 32'h0);
      tbl[19] = mk(0, 1, 32, 0, 0, 0,  0,  32'h0,          1, 0, 0, 0, 32'h0);
      tbl[20] = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 1, 0, 32'hDEAD_BEEF);
      tbl[21] = mk(0, 1, 1,  0, 0, 0,  0,  32'h0,          1, 0, 0, 0, 32'h0);
      tbl[22] = mk(1, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 0, 32'h0);
      tbl[23] = mk(0, 1, 2,  1, 0, 0,  16, 32'h0,          0, 1, 0, 0, 32'h0);
      tbl[24] = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 1, 32'h11BB_33DD);
      tbl[25] = mk(0, 0, 0,  1, 1, 0,  3,  32'hFFFF_FFFF,  0, 1, 0, 0, 32'h0);
      tbl[26] = mk(0, 0, 0,  1, 0, 0,  3,  32'h0,          0, 1, 0, 0, 32'h0);
      tbl[27] = mk(0, 0, 0,  0, 0, 0,  0,  32'h0,          0, 0, 0, 1, 32'hC0DE_0003);

      for (int n = 0; n < N_VEC; n++) begin
         step(tbl[n].rst, tbl[n].iv, tbl[n].ia, tbl[n].dv, tbl[n].dwr,
              tbl[n].dbe, tbl[n].da, tbl[n].dwd);
         chk($sformatf("tbl[%0d] i_req_ready", n), 32'(i_req_ready), 32'(tbl[n].e_ir));
         chk($sformatf("tbl[%0d] d_req_ready", n), 32'(d_req_ready), 32'(tbl[n].e_dr));
         chk($sformatf("tbl[%0d] i_rsp_valid", n), 32'(i_rsp_valid), 32'(tbl[n].e_iv));
         chk($sformatf("tbl[%0d] d_rsp_valid", n), 32'(d_rsp_valid), 32'(tbl[n].e_dv));
         if (tbl[n].e_iv) chk($sformatf("tbl[%0d] i_rsp_rdata", n), i_rsp_rdata, tbl[n].e_data);
         if (tbl[n].e_dv) chk($sformatf("tbl[%0d] d_rsp_rdata", n), d_rsp_rdata, tbl[n].e_data);
      end

      // Randomized mixed traffic over a small address window so reads hit recent writes.
      for (int n = 0; n < 600; n++) begin
         step(1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 1)),
              11'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)),
              11'($urandom_range(0, 15)),
              32'($urandom));
      end

      step(1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 4'd0, 11'd0, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/local_ram_arb.md
# local_ram_arb

Two-port arbiter that shares the single-ported local program/data RAM between the CPU instruction-fetch bus and the CPU data bus. Accepts valid/ready requests on each port, grants at most one per cycle using round-robin on conflict, drives the RAM's byte-write-strobe/read/address/write-data inputs, and routes the RAM's registered read data back to the port that issued the read. Sits between the rv32 core and the local RAM in the SoC top level.

## Interface
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, data width; byte strobes are DATA_W/8 = 4 bits.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  instruction read request
- i_req_ready  out  1  instruction request accepted this cycle
- i_req_addr  in  ADDR_W  instruction word address
- i_rsp_valid  out  1  instruction read data valid
- i_rsp_rdata  out  DATA_W  instruction read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_wr  in  1  1 = write, 0 = read
- d_req_be  in  4  byte enables for writes (ignored on reads)
- d_req_addr  in  ADDR_W  data word address
- d_req_wdata  in  DATA_W  write data
- d_rsp_valid  out  1  data read data valid (reads only)
- d_rsp_rdata  out  DATA_W  data read data
- ram_wr  out  4  RAM byte write strobes
- ram_rd  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered in RAM (1-cycle latency)

## Operation
- State: last_grant (I or D), pend_valid, pend_port.
- Grant (combinational from valids and last_grant): only one valid → grant it; both valid → grant the port that is not last_grant; none → no grant.
- Handshake = valid & ready on a port; exactly one ready high per cycle at most; ready never high without its valid.
- On grant: ram_addr = granted addr; I read or D read → ram_rd=1, ram_wr=0; D write → ram_wr = d_req_be, ram_rd=0, ram_wdata = d_req_wdata. No grant: ram_wr=0, ram_rd=0, ram_addr=0, ram_wdata=0.
- D write with d_req_be=0 is still a handshake (consumes the slot), no RAM change, no response.
- last_grant updates to the granted port on every handshake; held otherwise.
- Read handshake sets pend_valid=1, pend_port=granted port for the next cycle; otherwise pend_valid=0.
- Responses: x_rsp_valid = pend_valid & (pend_port==x); both rsp_rdata = ram_rdata (unqualified when not valid). No response backpressure; requester must accept.
- Writes produce no response; complete at handshake. Read after write to the same address in the next cycle returns new data.

## Timing
- Request accepted in cycle N (ready combinational, same cycle as valid); read data at x_rsp_valid in cycle N+1.
- Full throughput: one access per cycle; back-to-back reads from alternating ports each return in order, one cycle after their grant.
- Both ports continuously valid → grants alternate D, I, D, I... (after reset last_grant = I, so D wins the first conflict).
- Reset values: last_grant=I, pend_valid=0; during reset i/d_req_ready=0, i/d_rsp_valid=0, ram_wr=0, ram_rd=0.
- Reset asserted in cycle N+1 of a pending read: response suppressed and dropped.
- Requester may drop valid or change addr while not ready; no request is latched.

## Structure
- Package local_ram_pkg: port-id enum (PORT_I, PORT_D), default ADDR_W/DATA_W constants.
- Sub-module rr_arb2: two-request round-robin arbiter with last_grant register (inputs req[1:0], advance; outputs one-hot gnt[1:0]).

## Test plan
- I-only reads of addr 0x000..0x003 back-to-back → i_req_ready every cycle, i_rsp_rdata = preloaded words one cycle later, d_rsp_valid stays 0.
- D write addr 0x010, be=4'b0101, wdata=0xAABBCCDD over 0x11223344, then D read 0x010 → d_rsp_rdata=0x11BB33DD next cycle.
- Both ports valid for 6 cycles from reset → grant order D,I,D,I,D,I; each rsp_valid on correct port only, cycle after its grant.
- D write 0x020=0xDEADBEEF in cycle N, I read 0x020 in N+1 → i_rsp_rdata=0xDEADBEEF in N+2.
- I read granted in N, reset high in N+1 → i_rsp_valid=0, readies 0, ram_wr/ram_rd 0 during reset; after reset D wins first conflict.
